// File: rtl/bp_fpga_host_pkg.sv
// Shared NBF definitions for the FPGA host: opcode enum and the packet struct macro.
// Field order keeps the opcode in the low byte so LSB-first serialization emits it first.
`ifndef BP_FPGA_HOST_PKG_SV
`define BP_FPGA_HOST_PKG_SV

`define BP_FPGA_HOST_NBF_S(addr_width_mp, data_width_mp) \
  typedef struct packed { \
    logic [data_width_mp-1:0]                   data; \
    logic [addr_width_mp-1:0]                   addr; \
    bp_fpga_host_pkg::bp_fpga_host_nbf_opcode_e opcode; \
  } bp_fpga_host_nbf_s

package bp_fpga_host_pkg;

  localparam int nbf_opcode_width_gp = 8;

  typedef enum logic [nbf_opcode_width_gp-1:0] {
    e_nbf_putch     = 8'h01,
    e_nbf_core_done = 8'h02,
    e_nbf_error     = 8'h03,
    e_nbf_status    = 8'h10,
    e_nbf_read_resp = 8'h20,
    e_nbf_fence     = 8'hfe,
    e_nbf_finish    = 8'hff
  } bp_fpga_host_nbf_opcode_e;

endpackage

`endif

// File: rtl/bp_fpga_host_tx_rr_arb.sv
// Combinational pick: requester 0 by strict priority, others round-robin from ptr_i.
// force_rr_i lets the round-robin winner pre-empt requester 0 when one exists.
module bp_fpga_host_tx_rr_arb
  import bp_fpga_host_pkg::*;
 #(parameter int num_req_p  = 3
  ,parameter int id_width_p = $clog2(num_req_p)
  )
  (input  logic [num_req_p-1:0]  v_i
  ,input  logic [id_width_p-1:0] ptr_i
  ,input  logic                  force_rr_i
  ,output logic [num_req_p-1:0]  grant_oh_o
  ,output logic [id_width_p-1:0] grant_id_o
  ,output logic                  v_o
  );

  logic                  rr_found;
  logic [id_width_p-1:0] rr_id;
  int                    idx;

  // Walk ptr..N-1 then 1..ptr-1; index 0 never takes part in the rotation.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    idx      = 0;
    for (int off = 0; off < num_req_p-1; off++) begin
      idx = ((int'(ptr_i) - 1 + off) % (num_req_p - 1)) + 1;
      if (!rr_found && v_i[idx]) begin
        rr_found = 1'b1;
        rr_id    = id_width_p'(idx);
      end
    end
  end

  always_comb begin
    v_o        = |v_i;
    grant_id_o = (v_i[0] && !(force_rr_i && rr_found)) ? '0 : rr_id;
    grant_oh_o = '0;
    if (v_o)
      grant_oh_o[grant_id_o] = 1'b1;
  end

endmodule

// File: rtl/bp_fpga_host_tx_scheduler.sv
// Arbitrates whole NBF packets from several producers onto one UART TX beat stream.
// Optional starvation guard for requesters 1..N-1: BP_FPGA_HOST_TX_STARVE_GUARD_EN.
module bp_fpga_host_tx_scheduler
  import bp_fpga_host_pkg::*;
 #(parameter int num_req_p        = 3
  ,parameter int nbf_addr_width_p = 40
  ,parameter int nbf_data_width_p = 64
  ,parameter int uart_data_bits_p = 8
  ,parameter int starve_limit_p   = 4
  ,localparam int nbf_width_lp    = 8 + nbf_addr_width_p + nbf_data_width_p
  ,localparam int nbf_beats_lp    = nbf_width_lp / uart_data_bits_p
  ,localparam int id_width_lp     = $clog2(num_req_p)
  )
  (input  logic                                     clk_i
  ,input  logic                                     reset_i
  ,input  logic [num_req_p-1:0][nbf_width_lp-1:0]   nbf_i
  ,input  logic [num_req_p-1:0]                     nbf_v_i
  ,output logic [num_req_p-1:0]                     nbf_yumi_o
  ,output logic [uart_data_bits_p-1:0]              tx_o
  ,output logic                                     tx_v_o
  ,input  logic                                     tx_ready_and_i
  ,output logic                                     busy_o
  ,output logic [id_width_lp-1:0]                   grant_id_o
  );

  `BP_FPGA_HOST_NBF_S(nbf_addr_width_p, nbf_data_width_p);

  localparam int cnt_width_lp = $clog2(nbf_beats_lp);
  localparam logic [0:0] e_idle = 1'b0;
  localparam logic [0:0] e_send = 1'b1;

  logic [0:0]              state_r;
  logic [cnt_width_lp-1:0] cnt_r;
  logic [id_width_lp-1:0]  rr_ptr_r, grant_id_r;
  bp_fpga_host_nbf_s       pkt_r;
  logic [nbf_width_lp-1:0] pkt_flat;

  logic                    beat_acc, last_acc, arb_en, grant_v, force_rr;
  logic [num_req_p-1:0]    arb_oh;
  logic [id_width_lp-1:0]  arb_id;
  logic                    arb_v;

  bp_fpga_host_tx_rr_arb
   #(.num_req_p(num_req_p), .id_width_p(id_width_lp))
   arb
    (.v_i(nbf_v_i)
    ,.ptr_i(rr_ptr_r)
    ,.force_rr_i(force_rr)
    ,.grant_oh_o(arb_oh)
    ,.grant_id_o(arb_id)
    ,.v_o(arb_v)
    );

  assign tx_v_o   = (state_r == e_send);
  assign busy_o   = tx_v_o;
  assign beat_acc = tx_v_o & tx_ready_and_i;
  assign last_acc = beat_acc & (cnt_r == cnt_width_lp'(nbf_beats_lp-1));
  // Arbitrating on the last accepted beat gives back-to-back packets with no bubble.
  assign arb_en   = (state_r == e_idle) | last_acc;
  assign grant_v  = arb_en & arb_v;

  assign nbf_yumi_o = arb_en ? arb_oh : '0;
  assign pkt_flat   = pkt_r;
  assign tx_o       = pkt_flat[cnt_r*uart_data_bits_p +: uart_data_bits_p];
  assign grant_id_o = grant_id_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      cnt_r      <= '0;
      rr_ptr_r   <= id_width_lp'(1);
      grant_id_r <= '0;
    end else if (grant_v) begin
      state_r    <= e_send;
      cnt_r      <= '0;
      grant_id_r <= arb_id;
      if (arb_id != '0)
        rr_ptr_r <= (arb_id == id_width_lp'(num_req_p-1)) ? id_width_lp'(1) : arb_id + 1'b1;
    end else if (last_acc) begin
      state_r <= e_idle;
      cnt_r   <= '0;
    end else if (beat_acc) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i)
    if (grant_v)
      pkt_r <= bp_fpga_host_nbf_s'(nbf_i[arb_id]);

`ifdef BP_FPGA_HOST_TX_STARVE_GUARD_EN
  localparam int starve_width_lp = $clog2(starve_limit_p+1);
  logic [starve_width_lp-1:0] starve_cnt_r;

  assign force_rr = (starve_cnt_r >= starve_width_lp'(starve_limit_p));

  // Only requester-0 wins that actually pushed someone else aside count toward starvation.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      starve_cnt_r <= '0;
    else if (grant_v) begin
      if (arb_id != '0)
        starve_cnt_r <= '0;
      else if ((|nbf_v_i[num_req_p-1:1]) && !force_rr)
        starve_cnt_r <= starve_cnt_r + 1'b1;
    end
  end
`else
  assign force_rr = 1'b0;
`endif

endmodule

// File: tb/tb_bp_fpga_host_tx_scheduler.sv
// Random and directed stimulus for the TX scheduler against a byte-queue reference model.
module tb_bp_fpga_host_tx_scheduler;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [2:0][111:0] nbf_i;
  logic [2:0]       nbf_v_i;
  logic [2:0]       nbf_yumi_o;
  logic [7:0]       tx_o;
  logic             tx_v_o;
  logic             tx_ready_and_i;
  logic             busy_o;
  logic [1:0]       grant_id_o;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  bp_fpga_host_tx_scheduler dut
    (.clk_i(clk), .reset_i(reset_i), .nbf_i(nbf_i), .nbf_v_i(nbf_v_i)
    ,.nbf_yumi_o(nbf_yumi_o), .tx_o(tx_o), .tx_v_o(tx_v_o)
    ,.tx_ready_and_i(tx_ready_and_i), .busy_o(busy_o), .grant_id_o(grant_id_o));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [111:0] mk(input logic [7:0] op, input logic [39:0] addr, input logic [63:0] data);
    return {data, addr, op};
  endfunction

  // Reference model: bytes still owed by the packet in flight, arbitration state, logs.
  logic [7:0] q[$];
  logic [7:0] acc[$];
  int         glog[$];
  int         m_ptr = 1, m_starve = 0, m_gid = 0;

  function automatic int pick(input logic [2:0] v);
    int rr = -1;
    for (int k = 0; k < 2; k++) begin
      int c = m_ptr + k;
      if (c > 2) c = c - 2;
      if (rr < 0 && v[c]) rr = c;
    end
`ifdef BP_FPGA_HOST_TX_STARVE_GUARD_EN
    if (v[0] && !(m_starve >= 4 && rr >= 0)) return 0;
`else
    if (v[0]) return 0;
`endif
    return rr;
  endfunction

  logic [2:0]   ey;
  logic [111:0] p;
  int           w;
  bit           can;

  always @(negedge clk) begin
    if (reset_i) begin
      q.delete();
      m_ptr = 1; m_starve = 0; m_gid = 0;
    end else begin
      chk("tx_v", tx_v_o, q.size() > 0);
      chk("busy", busy_o, q.size() > 0);
      chk("grant_id", grant_id_o, m_gid);
      if (q.size() > 0) chk("tx_byte", tx_o, q[0]);
      can = (q.size() == 0) || (q.size() == 1 && tx_ready_and_i);
      w   = (can && nbf_v_i != 3'b000) ? pick(nbf_v_i) : -1;
      ey  = '0;
      if (w >= 0) ey[w] = 1'b1;
      chk("yumi", nbf_yumi_o, ey);
      if (q.size() > 0 && tx_ready_and_i) begin
        acc.push_back(q[0]);
        void'(q.pop_front());
      end
      if (w >= 0) begin
        p = nbf_i[w];
        q.push_back(p[7:0]);
        for (int i = 0; i < 5; i++) q.push_back(8'(p[8+:40] >> (8*i)));
        for (int i = 0; i < 8; i++) q.push_back(8'(p[48+:64] >> (8*i)));
        glog.push_back(w);
        m_gid = w;
        if (w != 0) begin
          m_starve = 0;
          m_ptr = (w == 2) ? 1 : w + 1;
        end else if (nbf_v_i[2:1] != 2'b00 && m_starve < 4) begin
          m_starve++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; cyc(); cyc(); reset_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() > 0 || busy_o) && n < 300) begin cyc(); n++; end
    chk("idle_timeout", busy_o, 1'b0);
  endtask

  // Hold each requester in mask valid until it is consumed.
  task automatic serve(input logic [2:0] mask);
    int n = 0;
    nbf_v_i = mask;
    while (mask != 3'b000 && n < 300) begin
      @(negedge clk);
      mask = mask & ~nbf_yumi_o;
      @(posedge clk); #1;
      nbf_v_i = mask;
      n++;
    end
    chk("serve_timeout", mask, 3'b000);
  endtask

  task automatic run_grants(input logic [2:0] mask, input int cnt);
    int base = glog.size();
    int n = 0;
    nbf_v_i = mask;
    while (glog.size() < base + cnt && n < 1000) begin cyc(); n++; end
    nbf_v_i = 3'b000;
    chk("grants_timeout", glog.size() >= base + cnt, 1'b1);
  endtask

  logic [7:0] exp1 [14] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h41,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [3:0] pat = 4'b1001;
  int         base;

  initial begin
    reset_i = 1'b1; nbf_v_i = '0; tx_ready_and_i = 1'b1;
    for (int k = 0; k < 3; k++) nbf_i[k] = mk(8'(k + 1), 40'(k), 64'(k));
    do_reset();
    cyc();
    chk("reset_tx_v", tx_v_o, 1'b0);
    chk("reset_gid", grant_id_o, 2'd0);

    // single req1 packet, byte order
    nbf_i[1] = mk(8'h01, 40'h3, 64'h41);
    base = acc.size();
    serve(3'b010);
    wait_idle();
    for (int i = 0; i < 14; i++)
      chk($sformatf("req1_byte%0d", i), (acc.size() > base + i) ? acc[base + i] : 8'hxx, exp1[i]);

    // req0 and req2 together: 0 then 2 back to back
    base = glog.size();
    nbf_i[0] = mk(8'h02, 40'h10, 64'h1234); nbf_i[2] = mk(8'h20, 40'h20, 64'h5678);
    serve(3'b101);
    wait_idle();
    chk("pri_first", glog.size() > base ? glog[base] : -1, 0);
    chk("pri_second", glog.size() > base + 1 ? glog[base + 1] : -1, 2);

    // req1/req2 round-robin
    base = glog.size();
    run_grants(3'b110, 6);
    wait_idle();
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr%0d", i), glog.size() > base + i ? glog[base + i] : -1, (i % 2) ? 2 : 1);

    // stalls: tx_o must hold, exactly 14 beats
    base = acc.size();
    nbf_i[1] = mk(8'h10, 40'hab_cdef_0123, 64'h0011_2233_4455_6677);
    nbf_v_i = 3'b010;
    for (int k = 0; k < 80; k++) begin
      tx_ready_and_i = pat[k % 4];
      @(negedge clk);
      if (nbf_yumi_o[1]) begin @(posedge clk); #1; nbf_v_i = 3'b000; end
      else cyc();
    end
    tx_ready_and_i = 1'b1;
    wait_idle();
    chk("stall_beats", acc.size() - base, 14);

    // mid-packet reset, then RR pointer back at 1
    serve(3'b010);
    base = acc.size();
    for (int n = 0; n < 50 && acc.size() < base + 5; n++) cyc();
    reset_i = 1'b1; cyc(); reset_i = 1'b0;
    chk("post_reset_tx_v", tx_v_o, 1'b0);
    base = glog.size();
    run_grants(3'b110, 1);
    wait_idle();
    chk("post_reset_rr", glog.size() > base ? glog[base] : -1, 1);

    // requester 0 always valid alongside requester 1
    do_reset();
    base = glog.size();
    run_grants(3'b011, 10);
    wait_idle();
    for (int i = 0; i < 10; i++)
`ifdef BP_FPGA_HOST_TX_STARVE_GUARD_EN
      chk($sformatf("starve%0d", i), glog.size() > base + i ? glog[base + i] : -1, (i % 5 == 4) ? 1 : 0);
`else
      chk($sformatf("strict%0d", i), glog.size() > base + i ? glog[base + i] : -1, 0);
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      nbf_v_i = 3'($urandom);
      tx_ready_and_i = ($urandom_range(0, 3) != 0);
      reset_i = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < 3; k++)
        nbf_i[k] = mk(8'($urandom), 40'({$urandom, $urandom}), {$urandom, $urandom});
      cyc();
    end
    reset_i = 1'b0; nbf_v_i = '0; tx_ready_and_i = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/bp_fpga_host_tx_scheduler.md
Name: bp_fpga_host_tx_scheduler

Overview:
Shares the single host-bound UART TX byte stream between several NBF packet sources: host-input responses, BP io_cmd putchar/finish, and debug/status. Each whole NBF packet is captured atomically and serialized byte-by-byte. Requester 0 has strict priority because it must never back-pressure the UART RX path; requesters 1..N-1 are served round-robin. Sits between the NBF producers and the UART TX module in the FPGA host.

Parameters:
num_req_p, 3, number of NBF requesters (2..8); index 0 is the high-priority port
nbf_addr_width_p, 40, NBF address field width
nbf_data_width_p, 64, NBF data field width
uart_data_bits_p, 8, bits per UART beat
nbf_width_lp (local), 8+nbf_addr_width_p+nbf_data_width_p = 112, packet width; must be a multiple of uart_data_bits_p
nbf_beats_lp (local), nbf_width_lp/uart_data_bits_p = 14, beats per packet
starve_limit_p, 4, consecutive req-0 grants before a forced RR grant (only with the optional feature)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
nbf_i  in  num_req_p*nbf_width_lp  packet per requester; slice k is requester k
nbf_v_i  in  num_req_p  per-requester valid
nbf_yumi_o  out  num_req_p  one-hot consume strobe
tx_o  out  uart_data_bits_p  outgoing UART beat
tx_v_o  out  1  beat valid
tx_ready_and_i  in  1  UART TX accepts a beat
busy_o  out  1  packet in flight
grant_id_o  out  clog2(num_req_p)  requester whose packet is in flight

Behaviour:
- Reset values: tx_v_o=0, nbf_yumi_o=0, busy_o=0, grant_id_o=0, beat counter=0, RR pointer=1, state=e_idle, starve counter=0.
- e_idle:
  - If any nbf_v_i: choose winner. Requester 0 wins if valid; otherwise the first valid index at or after the RR pointer, wrapping within 1..N-1.
  - Assert nbf_yumi_o[winner] in this cycle, register the packet and grant_id, go to e_send.
  - First tx_v_o appears the following cycle (1-cycle latency).
- e_send:
  - tx_v_o=1; tx_o = pkt_r[cnt*uart_data_bits_p +: uart_data_bits_p].
  - Byte order: opcode byte first, then address LSB to MSB, then data LSB to MSB.
  - cnt increments only when tx_v_o & tx_ready_and_i.
  - tx_o is stable while stalled.
  - busy_o=1.
- Last beat (cnt==nbf_beats_lp-1) accepted:
  - If a request is valid in the same cycle, arbitrate, yumi and capture it, reset cnt=0 and stay in e_send. This gives zero bubble between packets.
  - Otherwise go to e_idle.
- RR pointer advances to winner+1 (wrapping to 1) only when a requester in 1..N-1 is granted; it is unchanged on requester-0 grants.
- nbf_yumi_o is never asserted while a packet is mid-serialization; at most one bit is set per cycle.
- Requesters may drop or change nbf_v_i at any time; only the yumi cycle matters.
- Mid-packet reset: the in-flight packet is discarded, tx_v_o=0 in the next cycle, and no partial packet is resumed.
- A simultaneous last-beat accept and new request yields the back-to-back case above; the new winner is based on the RR pointer updated by the previous grant.

Optional Feature:
- Macro BP_FPGA_HOST_TX_STARVE_GUARD_EN.
- When defined:
  - A counter tracks consecutive requester-0 grants made while any requester 1..N-1 is valid.
  - When the count reaches starve_limit_p, the next arbitration grants the RR winner even if requester 0 is valid, then the counter clears.
  - The counter also clears on any non-0 grant.
- When undefined: requester 0 has pure strict priority and the counter logic is absent.

Decomposition:
- bp_fpga_host_pkg: nbf opcode enum (putch, core_done, ...) and the `bp_fpga_host_nbf_s struct macro, shared with the producers.
- Scheduler-local: state enum {e_idle, e_send}.
- One natural sub-module: bp_fpga_host_tx_rr_arb, combinational priority plus round-robin pick returning one-hot grant and index; the pointer register stays in the parent. Serializer counter stays inline.

Test Plan:
- Single req1 packet, opcode 0x01, addr 0x00_0000_0003, data 0x41, tx_ready_and_i=1 -> yumi[1] at cycle T, 14 beats from T+1: 01,03,00,00,00,00,41,00,…,00; then idle, busy_o=0.
- req0 and req2 valid together -> req0 granted first; req2 granted on req0's last beat with no idle cycle; grant_id_o 0 then 2.
- req1 and req2 continuously valid, req0 idle, 6 packets -> grant order 1,2,1,2,1,2.
- tx_ready_and_i toggling 1,0,0,1 pattern -> tx_o held stable during stalls, exactly 14 accepted beats, no yumi mid-packet.
- reset_i asserted at beat 5 of a packet -> tx_v_o=0 next cycle, RR pointer=1, next packet starts at the opcode byte.
- With BP_FPGA_HOST_TX_STARVE_GUARD_EN and starve_limit_p=4, req0 and req1 always valid -> grant sequence 0,0,0,0,1,0,0,0,0,1; without the macro -> req1 never granted.
